// File: rtl/cnn_pkg.sv
// Shared CNN pipeline definitions: FSM state encoding, address linearisation and
// seed helpers used by the convolution and pooling stages.
package cnn_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StDrain,
        StWrite,
        StFinish
    } pool_state_e;

    // Row-major linear address of (ch, row, col) in a CH x h x w buffer.
    function automatic int unsigned lin3(input int unsigned ch, input int unsigned row,
                                         input int unsigned col, input int unsigned h,
                                         input int unsigned w);
        return (ch * h + row) * w + col;
    endfunction

    function automatic longint sat_min(input int unsigned width);
        return -(longint'(1) << (width - 1));
    endfunction

endpackage

// File: rtl/relu_maxpool2d.sv
// Fused ReLU + POOLxPOOL max-pool: reads the conv buffer window by window and writes
// one pooled word per window to the pool buffer, channel-major.
module relu_maxpool2d
    import cnn_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned CHANNELS   = 8,
    parameter int unsigned IMG_SIZE   = 28,
    parameter int unsigned POOL       = 2,
    parameter int unsigned RELU       = 1,
    localparam int unsigned OS        = IMG_SIZE / POOL,
    localparam int unsigned IN_AW     = $clog2(CHANNELS * IMG_SIZE * IMG_SIZE),
    localparam int unsigned OUT_AW    = $clog2(CHANNELS * OS * OS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    output logic [IN_AW-1:0]             in_addr,
    output logic                         in_en,
    input  logic signed [DATA_WIDTH-1:0] in_q,
    output logic [OUT_AW-1:0]            out_addr,
    output logic                         out_en,
    output logic                         out_we,
    output logic signed [DATA_WIDTH-1:0] out_d,
    output logic                         busy,
    output logic                         done
);

    localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned OS_W = (OS > 1) ? $clog2(OS) : 1;
    localparam int unsigned P_W  = (POOL > 1) ? $clog2(POOL) : 1;

    localparam logic signed [DATA_WIDTH-1:0] SEED =
        (RELU != 0) ? '0 : DATA_WIDTH'(sat_min(DATA_WIDTH));

    if (IMG_SIZE % POOL != 0) begin : g_bad_pool
        $fatal(1, "relu_maxpool2d: IMG_SIZE must be a multiple of POOL");
    end

    pool_state_e state_q;

    logic [CH_W-1:0] ch_q;
    logic [OS_W-1:0] pr_q, pc_q;
    logic [P_W-1:0]  dr_q, dc_q;
    logic            sample_q;
    logic signed [DATA_WIDTH-1:0] max_q, max_d;

    logic            last_elem, last_win;
    logic [P_W-1:0]  nxt_dr, nxt_dc;
    logic [CH_W-1:0] nxt_ch;
    logic [OS_W-1:0] nxt_pr, nxt_pc;
    logic [IN_AW-1:0]  elem_addr, win_addr;
    logic [OUT_AW-1:0] wr_addr;

    always_comb begin
        last_elem = (dr_q == P_W'(POOL - 1)) && (dc_q == P_W'(POOL - 1));
        last_win  = (ch_q == CH_W'(CHANNELS - 1)) && (pr_q == OS_W'(OS - 1)) &&
                    (pc_q == OS_W'(OS - 1));

        nxt_dc = (dc_q == P_W'(POOL - 1)) ? '0 : dc_q + P_W'(1);
        nxt_dr = (dc_q == P_W'(POOL - 1)) ? dr_q + P_W'(1) : dr_q;

        nxt_pc = (pc_q == OS_W'(OS - 1)) ? '0 : pc_q + OS_W'(1);
        nxt_pr = pr_q;
        nxt_ch = ch_q;
        if (pc_q == OS_W'(OS - 1)) begin
            if (pr_q == OS_W'(OS - 1)) begin
                nxt_pr = '0;
                nxt_ch = ch_q + CH_W'(1);
            end else begin
                nxt_pr = pr_q + OS_W'(1);
            end
        end

        // in_q is only meaningful the cycle after an in_en cycle.
        max_d = (sample_q && (in_q > max_q)) ? in_q : max_q;

        elem_addr = IN_AW'(lin3(32'(ch_q), POOL * 32'(pr_q) + 32'(nxt_dr),
                                POOL * 32'(pc_q) + 32'(nxt_dc), IMG_SIZE, IMG_SIZE));
        win_addr  = IN_AW'(lin3(32'(nxt_ch), POOL * 32'(nxt_pr), POOL * 32'(nxt_pc),
                                IMG_SIZE, IMG_SIZE));
        wr_addr   = OUT_AW'(lin3(32'(ch_q), 32'(pr_q), 32'(pc_q), OS, OS));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            ch_q     <= '0;
            pr_q     <= '0;
            pc_q     <= '0;
            dr_q     <= '0;
            dc_q     <= '0;
            sample_q <= 1'b0;
            max_q    <= SEED;
            in_addr  <= '0;
            in_en    <= 1'b0;
            out_addr <= '0;
            out_en   <= 1'b0;
            out_we   <= 1'b0;
            out_d    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            sample_q <= in_en;
            max_q    <= max_d;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StIssue;
                        ch_q    <= '0;
                        pr_q    <= '0;
                        pc_q    <= '0;
                        dr_q    <= '0;
                        dc_q    <= '0;
                        max_q   <= SEED;
                        in_en   <= 1'b1;
                        in_addr <= '0;
                        busy    <= 1'b1;
                    end
                end
                StIssue: begin
                    if (last_elem) begin
                        in_en   <= 1'b0;
                        dr_q    <= '0;
                        dc_q    <= '0;
                        state_q <= StDrain;
                    end else begin
                        dr_q    <= nxt_dr;
                        dc_q    <= nxt_dc;
                        in_addr <= elem_addr;
                    end
                end
                StDrain: begin
                    // Last sample lands this cycle, so write the combinational max.
                    out_en   <= 1'b1;
                    out_we   <= 1'b1;
                    out_d    <= max_d;
                    out_addr <= wr_addr;
                    state_q  <= StWrite;
                end
                StWrite: begin
                    out_en <= 1'b0;
                    out_we <= 1'b0;
                    if (last_win) begin
                        done    <= 1'b1;
                        state_q <= StFinish;
                    end else begin
                        ch_q    <= nxt_ch;
                        pr_q    <= nxt_pr;
                        pc_q    <= nxt_pc;
                        max_q   <= SEED;
                        in_en   <= 1'b1;
                        in_addr <= win_addr;
                        state_q <= StIssue;
                    end
                end
                StFinish: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_relu_maxpool2d.sv
// Directed bench for relu_maxpool2d: a default-size instance against a golden max-pool
// model, plus two 1x4x4 instances (ReLU and plain max) with hand-computed results.
module tb_relu_maxpool2d;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   passed = 0;
    int   total  = 0;

    // Default-parameter instance.
    logic               start_a;
    logic [12:0]        in_addr_a;
    logic               in_en_a;
    logic signed [15:0] in_q_a;
    logic [10:0]        out_addr_a;
    logic               out_en_a, out_we_a;
    logic signed [15:0] out_d_a;
    logic               busy_a, done_a;

    // 1 channel, 4x4, RELU=1.
    logic               start_b;
    logic [3:0]         in_addr_b;
    logic               in_en_b;
    logic signed [15:0] in_q_b;
    logic [1:0]         out_addr_b;
    logic               out_en_b, out_we_b;
    logic signed [15:0] out_d_b;
    logic               busy_b, done_b;

    // 1 channel, 4x4, RELU=0.
    logic               start_c;
    logic [3:0]         in_addr_c;
    logic               in_en_c;
    logic signed [15:0] in_q_c;
    logic [1:0]         out_addr_c;
    logic               out_en_c, out_we_c;
    logic signed [15:0] out_d_c;
    logic               busy_c, done_c;

    relu_maxpool2d u_dut_a (
        .clk(clk), .reset(reset), .start(start_a),
        .in_addr(in_addr_a), .in_en(in_en_a), .in_q(in_q_a),
        .out_addr(out_addr_a), .out_en(out_en_a), .out_we(out_we_a), .out_d(out_d_a),
        .busy(busy_a), .done(done_a)
    );

    relu_maxpool2d #(.CHANNELS(1), .IMG_SIZE(4), .RELU(1)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b),
        .in_addr(in_addr_b), .in_en(in_en_b), .in_q(in_q_b),
        .out_addr(out_addr_b), .out_en(out_en_b), .out_we(out_we_b), .out_d(out_d_b),
        .busy(busy_b), .done(done_b)
    );

    relu_maxpool2d #(.CHANNELS(1), .IMG_SIZE(4), .RELU(0)) u_dut_c (
        .clk(clk), .reset(reset), .start(start_c),
        .in_addr(in_addr_c), .in_en(in_en_c), .in_q(in_q_c),
        .out_addr(out_addr_c), .out_en(out_en_c), .out_we(out_we_c), .out_d(out_d_c),
        .busy(busy_c), .done(done_c)
    );

    logic signed [15:0] mem_a [6272];
    logic signed [15:0] pool_a [1568];
    logic signed [15:0] mem_b [16];
    logic signed [15:0] pool_b [4];
    logic signed [15:0] mem_c [16];
    logic signed [15:0] pool_c [4];

    // BRAM models: one-cycle read latency, synchronous write.
    always @(posedge clk) begin
        if (in_en_a) in_q_a <= mem_a[in_addr_a];
        if (out_en_a && out_we_a) pool_a[out_addr_a] <= out_d_a;
        if (in_en_b) in_q_b <= mem_b[in_addr_b];
        if (out_en_b && out_we_b) pool_b[out_addr_b] <= out_d_b;
        if (in_en_c) in_q_c <= mem_c[in_addr_c];
        if (out_en_c && out_we_c) pool_c[out_addr_c] <= out_d_c;
    end

    int   cyc = 0;
    int   writes_a = 0, done_cnt_a = 0, overlap_a = 0;
    int   start_cyc_a = 0, done_cyc_a = 0, last_we_cyc_a = 0;
    int   last_out_addr_a = -1, max_in_addr_a = -1;
    logic prev_busy_a = 1'b0;
    int   writes_b = 0, done_cnt_b = 0, writes_c = 0, done_cnt_c = 0;

    always @(negedge clk) begin
        cyc         <= cyc + 1;
        prev_busy_a <= busy_a;
        if (busy_a && !prev_busy_a) start_cyc_a <= cyc;
        if (in_en_a && (int'(in_addr_a) > max_in_addr_a)) max_in_addr_a <= int'(in_addr_a);
        if (out_en_a && out_we_a) begin
            writes_a        <= writes_a + 1;
            last_we_cyc_a   <= cyc;
            last_out_addr_a <= int'(out_addr_a);
        end
        if (in_en_a && out_we_a) overlap_a <= overlap_a + 1;
        if (done_a) begin
            done_cnt_a <= done_cnt_a + 1;
            done_cyc_a <= cyc;
        end
        if (out_en_b && out_we_b) writes_b <= writes_b + 1;
        if (done_b) done_cnt_b <= done_cnt_b + 1;
        if (out_en_c && out_we_c) writes_c <= writes_c + 1;
        if (done_c) done_cnt_c <= done_cnt_c + 1;
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    endtask

    task automatic set_win(input int pc, input int v0, input int v1, input int v2,
                           input int v3);
        mem_a[2 * pc]      = 16'(v0);
        mem_a[2 * pc + 1]  = 16'(v1);
        mem_a[28 + 2 * pc] = 16'(v2);
        mem_a[29 + 2 * pc] = 16'(v3);
    endtask

    // Independent ReLU max-pool model over the 8x28x28 buffer.
    function automatic int mismatches_a();
        int errs = 0;
        for (int ch = 0; ch < 8; ch++)
            for (int pr = 0; pr < 14; pr++)
                for (int pc = 0; pc < 14; pc++) begin
                    logic signed [15:0] m;
                    m = 16'sd0;
                    for (int dr = 0; dr < 2; dr++)
                        for (int dc = 0; dc < 2; dc++)
                            if (mem_a[(ch * 28 + 2 * pr + dr) * 28 + 2 * pc + dc] > m)
                                m = mem_a[(ch * 28 + 2 * pr + dr) * 28 + 2 * pc + dc];
                    if (pool_a[(ch * 14 + pr) * 14 + pc] !== m) errs++;
                end
        return errs;
    endfunction

    task automatic wait_done_a(input int base);
        int n = 0;
        while (done_cnt_a == base && n < 20000) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
    endtask

    int base_w, base_d, w_at_reset;
    int exp_b [4] = '{0, 0, 0, 15};

    initial begin
        reset   = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;

        for (int a = 0; a < 6272; a++) mem_a[a] = $signed(16'($urandom));
        set_win(0, 32767, 100, 200, -32768);
        set_win(1, -32768, 500, 499, -1);
        set_win(2, 32766, -32768, 32767, 0);
        set_win(3, -32768, -32768, -32768, 1);
        // Ramp a-100, except window (1,1) holds its own addresses so its max is 15.
        for (int a = 0; a < 16; a++) begin
            mem_b[a] = 16'(a - 100);
            mem_c[a] = -16'sd3;
        end
        mem_b[10] = 16'sd10;
        mem_b[11] = 16'sd11;
        mem_b[14] = 16'sd14;
        mem_b[15] = 16'sd15;

        repeat (3) @(negedge clk);
        check("reset_outputs_a", longint'({in_addr_a, in_en_a, out_addr_a, out_en_a,
                                           out_we_a, out_d_a, busy_a, done_a}), 0);
        check("reset_outputs_b", longint'({in_addr_b, in_en_b, out_addr_b, out_en_b,
                                           out_we_b, out_d_b, busy_b, done_b}), 0);

        reset = 1'b0;
        @(negedge clk);
        start_a = 1'b1;
        start_b = 1'b1;
        start_c = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
        check("busy_after_start", longint'(busy_a), 1);
        check("first_read", longint'({in_en_a, in_addr_a}), longint'({1'b1, 13'd0}));

        repeat (48) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;

        wait_done_a(0);
        check("pass1_done_count", longint'(done_cnt_a), 1);
        check("pass1_writes", longint'(writes_a), 1568);
        check("pass1_en_to_done", longint'(done_cyc_a - start_cyc_a + 1), 9409);
        check("done_after_last_we", longint'(done_cyc_a - last_we_cyc_a), 1);
        check("en_we_overlap", longint'(overlap_a), 0);
        check("last_out_addr", longint'(last_out_addr_a), 1567);
        check("last_in_addr", longint'(max_in_addr_a), 6271);
        check("pass1_golden", longint'(mismatches_a()), 0);
        check("max_pos0_7fff", longint'(pool_a[0]), 32767);
        check("max_pos1", longint'(pool_a[1]), 500);
        check("max_pos2_7fff", longint'(pool_a[2]), 32767);
        check("max_pos3_vs_8000", longint'(pool_a[3]), 1);
        check("busy_cleared", longint'(busy_a), 0);

        check("ramp_writes", longint'(writes_b), 4);
        check("ramp_done", longint'(done_cnt_b), 1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("ramp_relu[%0d]", i), longint'(pool_b[i]), longint'(exp_b[i]));
            check($sformatf("neg3_plain[%0d]", i), longint'(pool_c[i]), -3);
        end
        check("plain_done", longint'(done_cnt_c), 1);

        for (int a = 0; a < 16; a++) mem_b[a] = -16'sd3;
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        repeat (40) @(negedge clk);
        check("neg3_relu_done", longint'(done_cnt_b), 2);
        for (int i = 0; i < 4; i++)
            check($sformatf("neg3_relu[%0d]", i), longint'(pool_b[i]), 0);

        // Abort a pass part-way through.
        base_d  = done_cnt_a;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (2998) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("reset_mid_outputs", longint'({in_addr_a, in_en_a, out_addr_a, out_en_a,
                                             out_we_a, out_d_a, busy_a, done_a}), 0);
        @(negedge clk);
        w_at_reset = writes_a;
        repeat (50) @(negedge clk);
        check("abort_no_writes", longint'(writes_a - w_at_reset), 0);
        check("abort_no_done", longint'(done_cnt_a - base_d), 0);

        // Fresh pass with new data after the abort.
        for (int a = 0; a < 6272; a++) mem_a[a] = $signed(16'($urandom));
        base_w  = writes_a;
        base_d  = done_cnt_a;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_done_a(base_d);
        check("pass3_done_count", longint'(done_cnt_a - base_d), 1);
        check("pass3_writes", longint'(writes_a - base_w), 1568);
        check("pass3_en_to_done", longint'(done_cyc_a - start_cyc_a + 1), 9409);
        check("pass3_golden", longint'(mismatches_a()), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
